// File: rtl/imm_encoder_pkg.sv
// Shared immediate-format select codes and the representability rule per format.
// Pure declarations: no latency, no flow control.
// Used by both the immediate decoder and the encoder pipeline.
package imm_encoder_pkg;

  localparam logic [2:0] IMM_I   = 3'b000;
  localparam logic [2:0] IMM_S   = 3'b001;
  localparam logic [2:0] IMM_B   = 3'b010;
  localparam logic [2:0] IMM_U   = 3'b011;
  localparam logic [2:0] IMM_J   = 3'b100;
  localparam logic [2:0] IMM_CSR = 3'b110;

  typedef struct packed {
    logic [2:0]  sel;
    logic [31:0] imm;
    logic [31:0] tmpl;
    logic        fits;
  } enc_req_t;

  // True when the immediate survives a pack/decode round trip in the chosen format.
  function automatic logic imm_fits(input logic [2:0] sel, input logic [31:0] imm);
    logic fits;
    case (sel)
      IMM_I, IMM_S: fits = (&imm[31:11]) | ~(|imm[31:11]);
      IMM_B:        fits = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
      IMM_U:        fits = ~(|imm[11:0]);
      IMM_J:        fits = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
      IMM_CSR:      fits = ~(|imm[31:5]);
      default:      fits = 1'b0;
    endcase
    return fits;
  endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Scatters an immediate into the instruction-word fields of the selected format.
// Purely combinational, zero latency; no flow control of its own.
// Unrepresentable immediates or bad selects return the template untouched with error set.
module imm_field_pack
  import imm_encoder_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic [31:0] imm,
  input  logic [31:0] tmpl,
  input  logic        fits,
  output logic [31:0] inst,
  output logic        error
);

  logic [31:0] packed_word;

  always_comb begin
    packed_word = tmpl;
    case (sel)
      IMM_I: packed_word[31:20] = imm[11:0];
      IMM_S: begin
        packed_word[31:25] = imm[11:5];
        packed_word[11:7]  = imm[4:0];
      end
      IMM_B: begin
        packed_word[31]    = imm[12];
        packed_word[7]     = imm[11];
        packed_word[30:25] = imm[10:5];
        packed_word[11:8]  = imm[4:1];
      end
      IMM_U: packed_word[31:12] = imm[31:12];
      IMM_J: begin
        packed_word[31]    = imm[20];
        packed_word[19:12] = imm[19:12];
        packed_word[20]    = imm[11];
        packed_word[30:21] = imm[10:1];
      end
      IMM_CSR: packed_word[19:15] = imm[4:0];
      default: packed_word = tmpl;
    endcase
  end

  // No partial packing: a failed check passes the template through whole.
  assign inst  = fits ? packed_word : tmpl;
  assign error = ~fits;

endmodule

// File: rtl/imm_encoder.sv
// Packs a 32-bit immediate into a RISC-V instruction template, flagging unrepresentable values.
// Two-stage pipeline: out_valid two cycles after accept, one result per cycle sustained.
// Full valid/ready backpressure; each stage advances when the stage downstream frees up.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_sel,
  input  logic [31:0]        in_imm,
  input  logic [31:0]        in_template,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_inst,
  output logic               out_error,
  output logic [COUNT_W-1:0] err_count
);

  logic        s1_vld;
  enc_req_t    s1_req;
  logic        s1_adv;
  logic        s2_adv;
  logic [31:0] pack_inst;
  logic        pack_err;

  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_vld | s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
    end else if (s1_adv) begin
      s1_vld <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && s1_adv) begin
      s1_req <= '{sel: in_sel, imm: in_imm, tmpl: in_template, fits: imm_fits(in_sel, in_imm)};
    end
  end

  imm_field_pack u_pack (
    .sel   (s1_req.sel),
    .imm   (s1_req.imm),
    .tmpl  (s1_req.tmpl),
    .fits  (s1_req.fits),
    .inst  (pack_inst),
    .error (pack_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_error <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_vld;
      if (s1_vld) begin
        out_inst  <= pack_inst;
        out_error <= pack_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (out_valid && out_ready && out_error && (err_count != '1)) begin
      err_count <= err_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: table-driven bit-position reference model, directed
// vectors, a backpressure scenario, and a long random run with a mid-stream reset.
module tb_imm_encoder;
  import imm_encoder_pkg::*;

  localparam int COUNT_W = 16;
  localparam int CNT_MAX = (1 << COUNT_W) - 1;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    logic [2:0]  sel;
    logic [31:0] imm;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_sel;
  logic [31:0]        in_imm;
  logic [31:0]        in_template;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [31:0]        out_inst;
  logic               out_error;
  logic [COUNT_W-1:0] err_count;

  int   n_checks = 0;
  int   n_err    = 0;
  int   n_acc    = 0;
  int   mcnt     = 0;
  bit   stall    = 1'b0;
  bit   rand_bp  = 1'b0;
  exp_t exp_q[$];

  imm_encoder #(.COUNT_W(COUNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sel      (in_sel),
    .in_imm      (in_imm),
    .in_template (in_template),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_error   (out_error),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  // Instruction bit that carries immediate bit k in a format, or -1 if that bit is not encoded.
  function automatic int pos_of(input logic [2:0] sel, input int k);
    case (sel)
      3'd0: return (k <= 11) ? 20 + k : -1;
      3'd1: return (k <= 4) ? 7 + k : (k <= 11) ? 20 + k : -1;
      3'd2: return (k >= 1 && k <= 4) ? 7 + k : (k >= 5 && k <= 10) ? 20 + k :
                   (k == 11) ? 7 : (k == 12) ? 31 : -1;
      3'd3: return (k >= 12) ? k : -1;
      3'd4: return (k >= 1 && k <= 10) ? 20 + k : (k == 11) ? 20 :
                   (k >= 12 && k <= 19) ? k : (k == 20) ? 31 : -1;
      3'd6: return (k <= 4) ? 15 + k : -1;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] decode(input logic [2:0] sel, input logic [31:0] inst);
    logic [31:0] v;
    int top;
    v = '0;
    top = -1;
    for (int k = 0; k < 32; k++) begin
      if (pos_of(sel, k) >= 0) begin
        v[k] = inst[pos_of(sel, k)];
        top = k;
      end
    end
    if (top >= 0 && sel != 3'd3 && sel != 3'd6)
      for (int k = top + 1; k < 32; k++) v[k] = v[top];
    return v;
  endfunction

  task automatic model(input logic [2:0] sel, input logic [31:0] imm, input logic [31:0] tmpl,
                       output logic [31:0] inst, output logic err);
    logic [31:0] w;
    w = tmpl;
    for (int k = 0; k < 32; k++)
      if (pos_of(sel, k) >= 0) w[pos_of(sel, k)] = imm[k];
    if (sel == 3'd5 || sel == 3'd7 || decode(sel, w) != imm) begin
      inst = tmpl;
      err  = 1'b1;
    end else begin
      inst = w;
      err  = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = stall ? 1'b0 : (rand_bp ? ($urandom_range(3) != 0) : 1'b1);
  end

  // Monitor: compares every consumed result, output stability under stall and the error counter.
  logic        hold_vld = 1'b0;
  logic [31:0] hold_inst;
  logic        hold_err;
  exp_t        me;
  always @(negedge clk) begin
    if (hold_vld) begin
      n_checks++;
      if (!(out_valid === 1'b1 && out_inst === hold_inst && out_error === hold_err)) begin
        n_err++;
        $display("FAIL hold_stable: got v=%b %h/%b, expected v=1 %h/%b",
                 out_valid, out_inst, out_error, hold_inst, hold_err);
      end
    end
    chk("err_count", 32'(err_count), 32'(mcnt));
    if (rst) begin
      exp_q.delete();
      mcnt = 0;
      hold_vld = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_output: got %h/%b, expected nothing", out_inst, out_error);
        end else begin
          me = exp_q.pop_front();
          chk("out_inst", out_inst, me.inst);
          chk("out_error", 32'(out_error), 32'(me.err));
          if (!out_error) chk("round_trip", decode(me.sel, out_inst), me.imm);
          if (me.err && mcnt < CNT_MAX) mcnt++;
        end
      end
      hold_vld  = out_valid && !out_ready;
      hold_inst = out_inst;
      hold_err  = out_error;
    end
  end

  task automatic send_exp(input logic [2:0] s, input logic [31:0] im, input logic [31:0] tm,
                          input logic [31:0] ex_inst, input logic ex_err);
    exp_t e;
    bit acc;
    in_valid = 1'b1;
    in_sel = s;
    in_imm = im;
    in_template = tm;
    acc = 1'b0;
    for (int c = 0; c < 1000 && !acc; c++) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        e.inst = ex_inst; e.err = ex_err; e.sel = s; e.imm = im;
        exp_q.push_back(e);
        n_acc++;
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_checks++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0 for 1000 cycles, expected accept");
    end
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] s, input logic [31:0] im, input logic [31:0] tm);
    logic [31:0] ei;
    logic ee;
    model(s, im, tm, ei, ee);
    send_exp(s, im, tm, ei, ee);
  endtask

  task automatic drain();
    for (int c = 0; c < 500 && exp_q.size() != 0; c++) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d results outstanding, expected 0", exp_q.size());
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by 1ms, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  s;
    logic [31:0] im;
    int base;
    rst = 1'b1;
    in_valid = 1'b0;
    in_sel = '0;
    in_imm = '0;
    in_template = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_inst", out_inst, 32'd0);
    chk("reset_out_error", 32'(out_error), 32'd0);
    @(posedge clk);
    #1;

    // Latency: nothing one cycle after accept, result two cycles after.
    send_exp(IMM_I, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
    @(negedge clk);
    chk("latency_cycle1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("latency_cycle2", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    send_exp(IMM_B, 32'hFFFF_F000, 32'h0000_0063, 32'h8000_0063, 1'b0);
    send_exp(IMM_J, 32'h0000_0002, 32'h0000_006F, 32'h0020_006F, 1'b0);
    send_exp(IMM_U, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0);
    send_exp(IMM_U, 32'h1234_5001, 32'h0000_0037, 32'h0000_0037, 1'b1);
    drain();

    do_reset();
    send_exp(IMM_I, 32'h0000_0800, 32'h0000_0013, 32'h0000_0013, 1'b1);
    send_exp(IMM_B, 32'h0000_0003, 32'h0000_0063, 32'h0000_0063, 1'b1);
    send_exp(3'b111, 32'h0000_0005, 32'hABCD_EF01, 32'hABCD_EF01, 1'b1);
    drain();
    @(negedge clk);
    chk("err_count_three", 32'(err_count), 32'd3);
    stall = 1'b1;
    @(posedge clk);
    #1;

    // Backpressure: two accepts fill the pipe, then release and expect a gap-free burst.
    base = n_acc;
    fork
      begin
        for (int k = 0; k < 4; k++) send(IMM_S, 32'(k * 37 - 50), 32'h0000_2023 + 32'(k << 12));
      end
      begin
        repeat (5) @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_accepts", 32'(n_acc - base), 32'd2);
        stall = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("bp_no_gap", 32'(out_valid), 32'd1);
        end
      end
    join
    @(posedge clk);
    #1;
    drain();

    rand_bp = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      s  = 3'($urandom_range(7));
      im = $urandom;
      case ($urandom_range(3))
        0: ;
        1: begin
          int b;
          b = $urandom_range(20, 4);
          for (int k = b + 1; k < 32; k++) im[k] = im[b];
        end
        2: im = im & 32'hFFFF_F000;
        default: im = 32'($urandom_range(63));
      endcase
      if ($urandom_range(1) == 0) im[0] = 1'b0;
      send(s, im, $urandom);
      if (n == 5000) do_reset();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
